fp_add_arbiter: RTL and testbench

- Shares one combinational single-precision (IEEE-754 binary32) adder instance between NUM_REQ requesters, e.g. ECG filter/feature-extraction channels.
- Grants requesters round-robin and registers operands into the adder.
- Registers the sum and returns it with the requester ID over a valid/ready response channel that supports backpressure.
- The adder itself is instantiated outside this block.

---
 rtl/fp_add_arbiter.sv | 120 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external binary32 adder between requesters.
// Operands are registered into the adder; sums return over valid/ready.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_res,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);

  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] win;
  logic            found;
  logic [IW-1:0]   idx;
  logic [ID_W+4:0] base;

  // Winner search starting at rr_ptr, wrapping by compare
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  // Pointer successor of the winner and its operand slice base
  always_comb begin
    ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    base    = {win, 5'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESULT;
      RESULT:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant vector and busy flag
  always_comb begin
    busy      = (state != IDLE);
    req_ready = '0;
    if (state == IDLE && found)
      req_ready = NUM_REQ'(1) << win;
  end

  // Operand capture, result capture and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      id_q       <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            add_a  <= req_a[base +: 32];
            add_b  <= req_b[base +: 32];
            id_q   <= win;
            rr_ptr <= ptr_nxt;
          end
        end
        ISSUE: begin
          resp_data  <= add_res;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
        end
        RESULT: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed testbench for fp_add_arbiter with a table-driven adder model.
// Each check is an immediate assertion against hand-computed values.
module tb_fp_add_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_res;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sum_tab [4];

  fp_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_res    (add_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External adder stand-in: exact sums for the operand pairs used here
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40A00000 && b == 32'hC0A00000) return 32'h00000000;
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return 32'h7FC00000;
  endfunction

  always_comb add_res = fadd(add_a, add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sum_tab[0] = 32'h40000000;
    sum_tab[1] = 32'h00000000;
    sum_tab[2] = 32'h40400000;
    sum_tab[3] = 32'h40800000;
    req_a = {32'h40000000, 32'h3F800000, 32'h40A00000, 32'h3F800000};
    req_b = {32'h40000000, 32'h40000000, 32'hC0A00000, 32'h3F800000};
    rst        = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request on port 2: 1.0 + 2.0
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("t1_busy_issue", 32'(busy), 32'd1);
    chk("t1_add_a", add_a, 32'h3F800000);
    chk("t1_add_b", add_b, 32'h40000000);
    chk("t1_no_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(resp_valid), 32'd1);
    chk("t1_data", resp_data, 32'h40400000);
    chk("t1_id", 32'(resp_id), 32'd2);
    chk("t1_busy_result", 32'(busy), 32'd1);
    tick();
    chk("t1_done_valid", 32'(resp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // All requesters valid from a fresh pointer: 0,1,2,3,0
    pulse_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1) << (k % 4));
      tick();
      chk($sformatf("rr%0d_ready_issue", k), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("rr%0d_ready_result", k), 32'(req_ready), 32'd0);
      chk($sformatf("rr%0d_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("rr%0d_id", k), 32'(resp_id), 32'(k % 4));
      chk($sformatf("rr%0d_data", k), resp_data, sum_tab[k % 4]);
      tick();
    end
    req_valid = 4'b0000;

    // Cancellation on port 1: 5.0 + -5.0
    req_valid = 4'b0010;
    #1;
    chk("t3_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t3_data", resp_data, 32'h00000000);
    chk("t3_id", 32'(resp_id), 32'd1);
    tick();

    // Backpressure with port 3 waiting
    resp_ready = 1'b0;
    req_valid  = 4'b1000;
    #1;
    chk("t4_ready0", 32'(req_ready), 32'h8);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_data", i), resp_data, 32'h40800000);
      chk($sformatf("bp%0d_id", i), 32'(resp_id), 32'd3);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("t4_ready_pre_accept", 32'(req_ready), 32'd0);
    tick();
    chk("t4_accepted", 32'(resp_valid), 32'd0);
    chk("t4_regrant", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t4_second_id", 32'(resp_id), 32'd3);
    tick();

    // Reset while holding a result
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t5_held", 32'(resp_valid), 32'd1);
    pulse_reset();
    #1;
    chk("t5_valid", 32'(resp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", resp_data, 32'd0);
    req_valid  = 4'b0011;
    resp_ready = 1'b1;
    #1;
    chk("t5_grant0", 32'(req_ready), 32'h1);
    tick();
    tick();
    chk("t5_id", 32'(resp_id), 32'd0);
    tick();
    chk("t5_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // Fairness after a grant to port 3
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    chk("t6_grant0", 32'(req_ready), 32'h1);
    tick();
    tick();
    chk("t6_id0", 32'(resp_id), 32'd0);
    tick();
    chk("t6_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t6_id3", 32'(resp_id), 32'd3);
    chk("t6_data3", resp_data, 32'h40800000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
